cix_seq: RTL and testbench
==========================

Name: cix_seq

Overview:
- Multi-cycle sequencer that applies the existing bit count unit (`cix`) to a wide operand of WORDS words of W bits, one word per cycle.
- Counts leading and trailing ones or zeroes across word boundaries, and stops early at the first word that is not entirely counted bits.
- For population and zero counts it sums the per-word results.
- Sits beside the ALU as a slow-path unit, with valid/ready on both the command and result sides.

Parameters:
- ORDER, 3, log2 of the word width; W = 2**ORDER; passed to `cix`.
- WORDS_LOG, 2, log2 of the word count; WORDS = 2**WORDS_LOG; operand width is WORDS*W.
- CW (local), ORDER+WORDS_LOG+1, width of the count result; holds 0..WORDS*W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready.
- in_op  in  3  cix opcode: CTO=010, CTZ=011, CLO=100, CLZ=101, PCNT=110, ZCNT=111.
- in_data  in  WORDS*W  operand; word i = bits [i*W+W-1 : i*W].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_count  out  CW  bit count result.
- out_all  out  1  1 when every bit of the operand matched the counted value.
- out_err  out  1  opcode was 000 or 001 (unsupported).

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_count=0, out_all=0, out_err=0.
  - Reset applies in any state, including mid-RUN or a DONE result that has not been consumed. That result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept, register op and data, and clear the accumulator.
  - Set the word index: WORDS-1 for CLO/CLZ (scan downward), 0 for all other ops (scan upward).
  - Go to RUN.
  - If op[2:1]==00, skip RUN and go straight to DONE with count=0, all=0, err=1.
- RUN (in_ready=0, out_valid=0):
  - Each cycle the selected word drives one `cix` instance with the registered op.
  - acc <= acc + cix.out, zero-extended to CW.
  - all_acc <= all_acc & cix.all; all_acc is initialised to 1 on accept.
  - Termination:
    - For CTO/CTZ/CLO/CLZ, go to DONE when cix.all==0 or when the last word is processed.
    - For PCNT/ZCNT, go to DONE only after the last word.
  - Otherwise step the index by +1 (upward) or -1 (downward).
  - The index never wraps; the last word is WORDS-1 for upward scans and 0 for downward scans.
- Latency: with k words processed, out_valid rises k cycles after the accept edge. k ranges from 1 to WORDS. An unsupported op has latency 1.
- DONE:
  - out_valid=1; out_count, out_all and out_err are held stable until out_ready.
  - On the handshake edge go to IDLE.
  - The next command can be accepted one cycle after the result handshake; there is no accept/result overlap.
- in_data and in_op changes outside the accept cycle have no effect.
- Outputs are registered; no combinational path runs from in_* to out_*.
- out_count in IDLE and RUN holds the last result, or 0 after reset. Only out_valid qualifies it.

Decomposition:
- Shared package/header: the CIX_* opcode constants, already defined with the `cix` unit. Add a predicate "op is scan-type" (op[2]^op[1] set, i.e. CTO..CLZ) and a predicate "op is downward" (op[2] & ~op[1]).
- Sub-module: a single instance of the existing `cix` with ORDER=ORDER. The sequencer's control and the accumulator stay in `cix_seq`.
- A word-select mux indexed by the registered word index is inline logic.

Test Plan (ORDER=3, WORDS_LOG=2, 32-bit operand):
- CLZ, data=0x0000_1234 -> out_count=19, out_all=0, out_err=0; out_valid 3 cycles after accept (words 3, 2, 1).
- CTZ, data=0x0000_0000 -> out_count=32, out_all=1; latency 4. Then CTO, data=0x0000_00FF -> out_count=8, out_all=0; latency 2.
- PCNT, data=0xFFFF_0001 -> out_count=17, latency 4. ZCNT on the same data -> 15.
- Backpressure: CLO, data=0xFFFF_FFFF, out_ready=0 for 5 cycles -> out_valid stays 1, out_count=32 and out_all=1 stay stable, in_ready=0; a single accept happens after out_ready=1.
- Reset asserted during the 2nd RUN cycle of a PCNT -> next cycle IDLE, in_ready=1, out_valid=0, out_count=0. A following CTZ of 0x8000_0000 gives 31.
- Op 000 with data=0x1234_5678 -> out_valid 1 cycle after accept, out_count=0, out_all=0, out_err=1.

Source files
------------

// File: rtl/cix_seq_pkg.sv
// ============================================================================
// Module  : cix_seq_pkg
// Brief   : Opcodes, FSM state type and opcode predicates shared by cix and
//           the multi-word cix sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cix_seq_pkg;

    localparam logic [2:0] CIX_CTO  = 3'b010;
    localparam logic [2:0] CIX_CTZ  = 3'b011;
    localparam logic [2:0] CIX_CLO  = 3'b100;
    localparam logic [2:0] CIX_CLZ  = 3'b101;
    localparam logic [2:0] CIX_PCNT = 3'b110;
    localparam logic [2:0] CIX_ZCNT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    // Leading/trailing count: stops at the first word that breaks the run.
    function automatic logic is_scan(input logic [2:0] op);
        return op[2] ^ op[1];
    endfunction

    // Leading counts walk from the most significant word downward.
    function automatic logic is_down(input logic [2:0] op);
        return op[2] & ~op[1];
    endfunction

    // Opcodes 000 and 001 have no meaning for the count unit.
    function automatic logic is_unsup(input logic [2:0] op);
        return op[2:1] == 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cix_seq_if.sv
// ============================================================================
// Module  : cix_seq_if
// Brief   : Command/result valid-ready bundle of the cix sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cix_seq_if #(
    parameter int ORDER     = 3,
    parameter int WORDS_LOG = 2
);
    localparam int W  = 2 ** ORDER;
    localparam int DW = (2 ** WORDS_LOG) * W;
    localparam int CW = ORDER + WORDS_LOG + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_all;
    logic          out_err;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_all, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_count, out_all, out_err
    );
endinterface

`default_nettype wire

// File: rtl/cix_seq_cix.sv
// ============================================================================
// Module  : cix
// Brief   : Single-word bit count unit: trailing/leading ones/zeroes and
//           population/zero counts of one W-bit word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cix
    import cix_seq_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  wire logic [2:0]            op_i,
    input  wire logic [(2**ORDER)-1:0] data_i,
    output logic      [ORDER:0]        count_o,
    output logic                       all_o
);
    localparam int W = 2 ** ORDER;

    logic [W-1:0] w_x;     // word with the counted value mapped to 1
    logic [W-1:0] w_r;     // w_x, bit-reversed for leading counts
    logic         w_run;

    // Counted value is 1 for even opcodes and 0 for odd ones; invert so the
    // counting loop always looks for ones starting from bit 0.
    always_comb begin
        w_x     = op_i[0] ? ~data_i : data_i;
        w_r     = w_x;
        w_run   = 1'b1;
        count_o = '0;
        if (is_down(op_i)) begin
            for (int i = 0; i < W; i++) begin
                w_r[i] = w_x[W-1-i];
            end
        end
        for (int i = 0; i < W; i++) begin
            if (op_i[2:1] == 2'b11) begin
                count_o = count_o + (ORDER+1)'(w_r[i]);
            end else if (w_run && w_r[i]) begin
                count_o = count_o + (ORDER+1)'(1);
            end else begin
                w_run = 1'b0;
            end
        end
        all_o = &w_x;
        if (is_unsup(op_i)) begin
            count_o = '0;
            all_o   = 1'b0;
        end
    end
endmodule

`default_nettype wire

// File: rtl/cix_seq.sv
// ============================================================================
// Module  : cix_seq
// Brief   : Multi-cycle sequencer running one cix unit over a WORDS*W-bit
//           operand, one word per cycle, with early stop for scan counts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cix_seq
    import cix_seq_pkg::*;
#(
    parameter int ORDER     = 3,
    parameter int WORDS_LOG = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    cix_seq_if.slave  bus
);
    localparam int W  = 2 ** ORDER;
    localparam int DW = (2 ** WORDS_LOG) * W;
    localparam int CW = ORDER + WORDS_LOG + 1;

    seq_state_t             state_q;
    logic [2:0]             op_q;
    logic [DW-1:0]          data_q;
    logic [WORDS_LOG-1:0]   idx_q;
    logic [CW-1:0]          acc_q;
    logic                   all_acc_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [CW-1:0]          count_q;
    logic                   all_q;
    logic                   err_q;

    logic [WORDS_LOG+ORDER-1:0] w_base;
    logic [W-1:0]               w_word;
    logic [ORDER:0]             w_cnt;
    logic                       w_all;
    logic [CW-1:0]              sum_d;
    logic                       all_d;
    logic                       last_d;
    logic                       stop_d;

    assign w_base = {idx_q, ORDER'(0)};
    assign w_word = data_q[w_base +: W];

    cix #(.ORDER(ORDER)) u_cix (
        .op_i    (op_q),
        .data_i  (w_word),
        .count_o (w_cnt),
        .all_o   (w_all)
    );

    assign sum_d  = acc_q + CW'(w_cnt);
    assign all_d  = all_acc_q & w_all;
    assign last_d = is_down(op_q) ? (idx_q == '0) : (idx_q == '1);
    assign stop_d = last_d | (is_scan(op_q) & ~w_all);

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            all_acc_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            all_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.in_op;
                        data_q     <= bus.in_data;
                        acc_q      <= '0;
                        all_acc_q  <= 1'b1;
                        idx_q      <= is_down(bus.in_op) ? '1 : '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Unsupported ops spend exactly one cycle here so their
                    // result shows the same one-cycle latency as a 1-word run.
                    if (is_unsup(op_q)) begin
                        count_q     <= '0;
                        all_q       <= 1'b0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (stop_d) begin
                        count_q     <= sum_d;
                        all_q       <= all_d;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q     <= sum_d;
                        all_acc_q <= all_d;
                        idx_q     <= is_down(op_q) ? idx_q - WORDS_LOG'(1)
                                                   : idx_q + WORDS_LOG'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = count_q;
    assign bus.out_all   = all_q;
    assign bus.out_err   = err_q;
endmodule

`default_nettype wire

// File: tb/tb_cix_seq.sv
// ============================================================================
// Module  : tb_cix_seq
// Brief   : Scoreboard bench for cix_seq (ORDER=3, WORDS_LOG=2, 32-bit data).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cix_seq;
    import cix_seq_pkg::*;

    typedef struct {
        logic [5:0] count;
        logic       all;
        logic       err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    cix_seq_if #(.ORDER(3), .WORDS_LOG(2)) bus ();

    cix_seq #(.ORDER(3), .WORDS_LOG(2)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model working on the whole 32-bit operand at once.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] d);
        exp_t e;
        logic [31:0] x;
        int n;
        n = 0;
        x = op[0] ? ~d : d;
        case (op)
            CIX_CTO, CIX_CTZ: while (n < 32 && x[n]) n++;
            CIX_CLO, CIX_CLZ: while (n < 32 && x[31-n]) n++;
            CIX_PCNT, CIX_ZCNT: n = $countones(x);
            default: n = 0;
        endcase
        e.count = 6'(n);
        e.err   = (op[2:1] == 2'b00);
        e.all   = !e.err && (n == 32);
        if (e.err)               e.lat = 1;
        else if (op[2:1] == 2'b11) e.lat = 4;
        else                     e.lat = (n / 8 + 1 > 4) ? 4 : n / 8 + 1;
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] data,
                        input int stall);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check_eq("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        sb_q.push_back(model(op, data));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_data  = $urandom;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb_q.pop_front();
        if (!bus.out_valid) begin
            check_eq("timeout", 0, 1);
            return;
        end
        check_eq("latency", 64'(cyc), 64'(e.lat));
        check_eq("count", bus.out_count, e.count);
        check_eq("all", bus.out_all, e.all);
        check_eq("err", bus.out_err, e.err);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", bus.out_valid, 1);
            check_eq("stall_count", bus.out_count, e.count);
            check_eq("stall_all", bus.out_all, e.all);
            check_eq("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq("post_valid", bus.out_valid, 0);
        check_eq("post_in_ready", bus.in_ready, 1);
        check_eq("hold_count", bus.out_count, e.count);
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  op;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_count", bus.out_count, 0);
        check_eq("rst_all", bus.out_all, 0);
        check_eq("rst_err", bus.out_err, 0);

        send(CIX_CLZ,  32'h0000_1234, 0);
        send(CIX_CTZ,  32'h0000_0000, 0);
        send(CIX_CTO,  32'h0000_00FF, 0);
        send(CIX_PCNT, 32'hFFFF_0001, 0);
        send(CIX_ZCNT, 32'hFFFF_0001, 0);
        send(CIX_CLO,  32'hFFFF_FFFF, 5);

        // Reset during the second RUN cycle of a PCNT discards the command.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = CIX_PCNT;
        bus.in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_in_ready", bus.in_ready, 1);
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_count", bus.out_count, 0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_result", bus.out_valid, 0);
        end
        send(CIX_CTZ, 32'h8000_0000, 0);

        send(3'b000, 32'h1234_5678, 0);
        send(3'b001, 32'hFFFF_FFFF, 0);
        send(CIX_CTZ, 32'h00FF_0000, 0);
        send(CIX_CLO, 32'hFFF0_0000, 2);

        for (int t = 0; t < 12; t++) begin
            op = 3'($urandom_range(2, 7));
            d  = $urandom;
            if ($urandom_range(0, 1) == 1)
                d = (op[0] ? 32'h0 : 32'hFFFF_FFFF) ^ (d >> $urandom_range(0, 31));
            send(op, d, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
